// File: rtl/decay_surface_map.sv
// decay_surface_map: per-cell timestamp store for the 16x16 DVS grid.
// Events stamp a cell with the current coarse tick. Reads return an
// activity value that falls linearly with the cell's age. A background
// scrubber clears cells old enough that timestamp wrap could alias them.
module decay_surface_map #(
    parameter int GRID_SIZE   = 16,
    parameter int ADDR_BITS   = 8,
    parameter int COORD_BITS  = 4,
    parameter int VALUE_BITS  = 8,
    parameter int TS_BITS     = 8,
    parameter int TICK_CYCLES = 12000,
    parameter int DECAY_SHIFT = 2,
    parameter int STALE_AGE   = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  event_valid,
    output logic                  event_ready,
    input  logic [COORD_BITS-1:0] event_x,
    input  logic [COORD_BITS-1:0] event_y,
    input  logic [ADDR_BITS-1:0]  read_addr,
    input  logic                  read_enable,
    output logic [VALUE_BITS-1:0] read_value,
    output logic [15:0]           event_count,
    output logic [15:0]           drop_count,
    output logic [TS_BITS-1:0]    now_ts
);

    localparam int NUM_CELLS = GRID_SIZE * GRID_SIZE;
    localparam int WORD_BITS = TS_BITS + 1;
    localparam int TICK_BITS = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    localparam logic [31:0]           VALUE_MAX  = 32'((64'd1 << VALUE_BITS) - 64'd1);
    localparam logic [31:0]           STALE_U    = 32'(STALE_AGE);
    localparam logic [31:0]           GRID_U     = 32'(GRID_SIZE);
    localparam logic [TICK_BITS-1:0]  TICK_LAST  = TICK_BITS'(TICK_CYCLES - 1);
    localparam logic [ADDR_BITS-1:0]  LAST_ADDR  = ADDR_BITS'(NUM_CELLS - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    // Word layout: {valid, ts}
    logic [WORD_BITS-1:0] mem_array [NUM_CELLS];

    state_t               state_reg;
    logic [ADDR_BITS-1:0] init_addr_reg;
    logic [TICK_BITS-1:0] tick_cnt_reg;
    logic [TS_BITS-1:0]   now_ts_reg;
    logic [ADDR_BITS-1:0] scrub_addr_reg;

    // Memory read register and the side information travelling with it
    logic [WORD_BITS-1:0] mem_q_reg;
    logic                 q_user_reg;
    logic                 q_scrub_reg;
    logic                 q_cancel_reg;
    logic [ADDR_BITS-1:0] q_addr_reg;
    logic [TS_BITS-1:0]   q_now_reg;

    // Classifier read pipeline
    logic [WORD_BITS-1:0]  s1_word_reg;
    logic [TS_BITS-1:0]    s1_now_reg;
    logic                  s1_user_reg;
    logic [VALUE_BITS-1:0] read_value_reg;

    logic [15:0] event_count_reg;
    logic [15:0] drop_count_reg;

    logic                 running;
    logic                 q_stale;
    logic                 invalidate;
    logic                 ev_accept;
    logic                 ev_in_range;
    logic                 ev_write;
    logic                 scrub_issue;
    logic [31:0]          ev_x_ext;
    logic [31:0]          ev_y_ext;
    logic [ADDR_BITS-1:0] ev_addr;
    logic [ADDR_BITS-1:0] rd_addr;
    logic [TS_BITS-1:0]   q_age;

    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_waddr;
    logic [WORD_BITS-1:0] mem_wdata;

    // Age is modular; the shift is done at 32 bits so nothing is lost.
    function automatic logic [VALUE_BITS-1:0] decay_value(
        input logic [WORD_BITS-1:0] word,
        input logic [TS_BITS-1:0]   now
    );
        logic [TS_BITS-1:0] age;
        logic [31:0]        scaled;
        age    = now - word[TS_BITS-1:0];
        scaled = 32'(age) << DECAY_SHIFT;
        if (word[TS_BITS] && (scaled <= VALUE_MAX)) begin
            decay_value = VALUE_BITS'(VALUE_MAX - scaled);
        end else begin
            decay_value = '0;
        end
    endfunction

    assign running     = (state_reg == ST_RUN);
    assign ev_x_ext    = 32'(event_x);
    assign ev_y_ext    = 32'(event_y);
    assign ev_in_range = (ev_x_ext < GRID_U) && (ev_y_ext < GRID_U);
    assign ev_addr     = ADDR_BITS'(ev_y_ext * GRID_U + ev_x_ext);

    // Scrub result is judged in the cycle after its read.
    assign q_age       = q_now_reg - mem_q_reg[TS_BITS-1:0];
    assign q_stale     = mem_q_reg[TS_BITS] && (32'(q_age) >= STALE_U);
    assign invalidate  = running && q_scrub_reg && !q_cancel_reg && q_stale;

    // The write port is lent to the scrubber, so events stall that cycle.
    assign event_ready = running && !invalidate;
    assign ev_accept   = event_valid && event_ready;
    assign ev_write    = ev_accept && ev_in_range;

    // Classifier owns the read port whenever it asks for it.
    assign scrub_issue = running && !read_enable;
    assign rd_addr     = read_enable ? read_addr : scrub_addr_reg;

    assign read_value  = read_value_reg;
    assign event_count = event_count_reg;
    assign drop_count  = drop_count_reg;
    assign now_ts      = now_ts_reg;

    // Select the single write source: init clear, invalidate, or event.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = init_addr_reg;
        mem_wdata = '0;
        if (!running) begin
            mem_we    = 1'b1;
        end else if (invalidate) begin
            mem_we    = 1'b1;
            mem_waddr = q_addr_reg;
            mem_wdata = {1'b0, mem_q_reg[TS_BITS-1:0]};
        end else if (ev_write) begin
            mem_we    = 1'b1;
            mem_waddr = ev_addr;
            mem_wdata = {1'b1, now_ts_reg};
        end
    end

    // Block RAM: one write, one registered read returning pre-write data.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_array[mem_waddr] <= mem_wdata;
        end
        mem_q_reg <= mem_array[rd_addr];
    end

    // INIT sweeps every cell to zero, then RUN until the next reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_INIT;
            init_addr_reg <= '0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    init_addr_reg <= init_addr_reg + ADDR_BITS'(1);
                    if (init_addr_reg == LAST_ADDR) begin
                        state_reg <= ST_RUN;
                    end
                end
                default: state_reg <= ST_RUN;
            endcase
        end
    end

    // Coarse time base, free running in both states.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_reg <= '0;
            now_ts_reg   <= '0;
        end else if (tick_cnt_reg == TICK_LAST) begin
            tick_cnt_reg <= '0;
            now_ts_reg   <= now_ts_reg + TS_BITS'(1);
        end else begin
            tick_cnt_reg <= tick_cnt_reg + TICK_BITS'(1);
        end
    end

    // Scrub address walk and tagging of what the read port fetched.
    always_ff @(posedge clk) begin
        if (rst) begin
            scrub_addr_reg <= '0;
            q_user_reg     <= 1'b0;
            q_scrub_reg    <= 1'b0;
            q_cancel_reg   <= 1'b0;
            q_addr_reg     <= '0;
            q_now_reg      <= '0;
        end else begin
            q_user_reg   <= read_enable && running;
            q_scrub_reg  <= scrub_issue;
            // A fresh event on the scrubbed cell makes the fetched word obsolete.
            q_cancel_reg <= scrub_issue && ev_write && (ev_addr == scrub_addr_reg);
            q_addr_reg   <= scrub_addr_reg;
            q_now_reg    <= now_ts_reg;
            if (scrub_issue) begin
                scrub_addr_reg <= (scrub_addr_reg == LAST_ADDR) ? '0
                                  : scrub_addr_reg + ADDR_BITS'(1);
            end
        end
    end

    // Read pipeline: register word and time, then compute decayed value.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_word_reg    <= '0;
            s1_now_reg     <= '0;
            s1_user_reg    <= 1'b0;
            read_value_reg <= '0;
        end else begin
            s1_word_reg    <= mem_q_reg;
            s1_now_reg     <= now_ts_reg;
            s1_user_reg    <= q_user_reg;
            read_value_reg <= s1_user_reg ? decay_value(s1_word_reg, s1_now_reg) : '0;
        end
    end

    // Accepted-event statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            event_count_reg <= '0;
            drop_count_reg  <= '0;
        end else if (ev_accept) begin
            if (!ev_in_range) begin
                drop_count_reg <= drop_count_reg + 16'd1;
            end else if (event_count_reg != 16'hFFFF) begin
                event_count_reg <= event_count_reg + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_decay_surface_map.sv
// Directed bench for decay_surface_map with a short tick so that full
// timestamp wraps fit in a small cycle count. Coordinates are one bit
// wider than the grid needs so out-of-range events can be offered.
module tb_decay_surface_map;

    localparam int CB   = 5;
    localparam int TICK = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          event_valid = 1'b0;
    logic          event_ready;
    logic [CB-1:0] event_x = '0;
    logic [CB-1:0] event_y = '0;
    logic [7:0]    read_addr = '0;
    logic          read_enable = 1'b0;
    logic [7:0]    read_value;
    logic [15:0]   event_count;
    logic [15:0]   drop_count;
    logic [7:0]    now_ts;

    int errors = 0;
    int checks = 0;
    int idle_re = 0;
    int exp_events = 0;

    always #5 clk = ~clk;

    decay_surface_map #(
        .GRID_SIZE   (16),
        .ADDR_BITS   (8),
        .COORD_BITS  (CB),
        .VALUE_BITS  (8),
        .TS_BITS     (8),
        .TICK_CYCLES (TICK),
        .DECAY_SHIFT (2),
        .STALE_AGE   (128)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .event_valid (event_valid),
        .event_ready (event_ready),
        .event_x     (event_x),
        .event_y     (event_y),
        .read_addr   (read_addr),
        .read_enable (read_enable),
        .read_value  (read_value),
        .event_count (event_count),
        .drop_count  (drop_count),
        .now_ts      (now_ts)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: got %0d", tag, obs);
        end
    endtask

    // Called at a negedge; value is sampled two edges after the request edge.
    task automatic do_read(input int addr, output int val);
        read_addr   = 8'(addr);
        read_enable = 1'b1;
        @(negedge clk);
        read_enable = 1'(idle_re);
        @(negedge clk);
        @(negedge clk);
        val = int'(read_value);
    endtask

    task automatic send_event(input int x, input int y);
        int n = 0;
        event_x     = CB'(x);
        event_y     = CB'(y);
        event_valid = 1'b1;
        while (!event_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("event_ready_timeout", n, 0);
        @(negedge clk);
        event_valid = 1'b0;
    endtask

    // Wait for a given timestamp, counting cycles with event_ready low.
    task automatic wait_now(input int target, output int lows);
        int n = 0;
        lows = 0;
        while (int'(now_ts) != target && n < 6000) begin
            if (!event_ready) lows++;
            @(negedge clk);
            n++;
        end
        if (n >= 6000) check("wait_now_timeout", int'(now_ts), target);
    endtask

    task automatic wait_tick();
        int n = 0;
        int cur;
        cur = int'(now_ts);
        while (int'(now_ts) == cur && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("wait_tick_timeout", int'(now_ts), cur + 1);
    endtask

    // Count INIT cycles while issuing reads that must all return zero.
    task automatic count_init(output int cyc, output int nz);
        cyc = 0;
        nz  = 0;
        while (!event_ready && cyc < 1000) begin
            if (read_value != 8'd0) nz++;
            read_addr   = 8'(cyc);
            read_enable = 1'b1;
            @(negedge clk);
            cyc++;
        end
        read_enable = 1'(idle_re);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, nz, v, pos, lows, a, b;

        // Power-on reset state
        repeat (3) @(negedge clk);
        check("rst_event_ready", int'(event_ready), 0);
        check("rst_read_value", int'(read_value), 0);
        check("rst_event_count", int'(event_count), 0);
        check("rst_drop_count", int'(drop_count), 0);
        check("rst_now_ts", int'(now_ts), 0);

        rst = 1'b0;
        count_init(c, nz);
        check("init_cycles", c, 256);
        check("init_reads_zero", nz, 0);
        check("now_after_init", int'(now_ts), 256 / TICK);
        do_read(83, v);
        check("read_after_init", v, 0);

        // Reset in the middle of RUN restarts INIT
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("ready_in_midrun_rst", int'(event_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        count_init(c, nz);
        check("reinit_cycles", c, 256);
        check("reinit_now_ts", int'(now_ts), 256 / TICK);
        check("reinit_event_count", int'(event_count), 0);

        // Out-of-range event: counted as drop, no cell written
        send_event(15, 16);
        check("oor_drop_count", int'(drop_count), 1);
        check("oor_event_count", int'(event_count), 0);
        do_read(15, v);
        check("oor_cell15", v, 0);
        do_read(255, v);
        check("oor_cell255", v, 0);

        // Full-rate scan with a single active cell at 17
        send_event(1, 1);
        check("scan_event_count", int'(event_count), 1);
        nz  = 0;
        pos = -1;
        for (int k = 0; k < 262; k++) begin
            if (read_value != 8'd0) begin
                nz++;
                pos = k;
            end
            read_addr   = 8'(k);
            read_enable = (k < 256);
            @(negedge clk);
        end
        read_enable = 1'b0;
        check("scan_nonzero_count", nz, 1);
        check("scan_nonzero_pos", pos, 17 + 3);

        // Scrub collision: fresh reset, scrubber frozen by read_enable
        idle_re     = 1;
        read_enable = 1'b1;
        read_addr   = 8'd200;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        count_init(c, nz);
        wait_now(20, lows);
        send_event(8, 2);
        send_event(9, 2);
        wait_now(160, lows);
        read_enable = 1'b0;
        repeat (40) @(negedge clk);
        read_enable = 1'b1;
        wait_tick();
        check("ready_before_collision", int'(event_ready), 1);
        event_x     = CB'(8);
        event_y     = CB'(2);
        event_valid = 1'b1;
        read_enable = 1'b0;
        @(negedge clk);
        event_valid = 1'b0;
        read_enable = 1'b1;
        check("ready_after_cancel", int'(event_ready), 1);
        check("collision_event_count", int'(event_count), 3);
        do_read(40, v);
        check("cell40_refreshed", v, 255);

        // Stale cell 41 invalidated while an event is held off
        read_enable = 1'b0;
        @(negedge clk);
        check("ready_in_invalidate", int'(event_ready), 0);
        event_x     = CB'(0);
        event_y     = CB'(3);
        event_valid = 1'b1;
        read_enable = 1'b1;
        @(negedge clk);
        check("held_not_taken", int'(event_count), 3);
        check("ready_after_invalidate", int'(event_ready), 1);
        @(negedge clk);
        event_valid = 1'b0;
        check("held_taken", int'(event_count), 4);
        wait_tick();
        do_read(48, v);
        check("cell48_one_tick", v, 251);
        idle_re     = 0;
        read_enable = 1'b0;
        exp_events  = 4;

        // Linear decay of cell (3,5) = 83
        wait_now(10, lows);
        send_event(3, 5);
        exp_events++;
        check("decay_event_count", int'(event_count), exp_events);
        do_read(83, v);
        check("decay_age0", v, 255);
        wait_now(12, lows);
        do_read(83, v);
        check("decay_age2", v, 247);
        wait_now(73, lows);
        do_read(83, v);
        check("decay_age63", v, 3);
        wait_now(74, lows);
        do_read(83, v);
        check("decay_age64", v, 0);

        // Wrap-around: cell 0 must not look fresh after 256 ticks
        wait_now(0, lows);
        check("sweep_invalidates_83", lows, 1);
        send_event(0, 0);
        do_read(0, v);
        check("wrap_fresh", v, 255);
        wait_now(1, a);
        wait_now(0, b);
        check("sweep_invalidates_0", a + b, 1);
        do_read(0, v);
        check("wrap_alias_zero", v, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
